pwm_duty_decoder: RTL and testbench

Recovers the duty value carried on an incoming PWM line. It is the receive-side counterpart of the team's 4-bit PWM generator, which uses a 16-clock frame. The block synchronises the line, measures high time and period between consecutive rising edges, and publishes a saturated duty code with a one-cycle valid strobe. It also detects lines stuck low or stuck high and flags frames whose period is off-nominal.

---
 rtl/pwm_duty_decoder_pkg.sv | 38 +++
 rtl/pwm_duty_decoder_if.sv | 27 ++
 rtl/pwm_sync_edge.sv | 34 +++
 rtl/pwm_duty_decoder.sv | 129 ++++++++++++
 tb/tb_pwm_duty_decoder.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_duty_decoder_pkg.sv
// Shared constants, state encoding and small arithmetic helpers for the
// PWM duty decoder. The widths, nominal period and state codes are common
// with the 4-bit / 16-clock PWM generator on the transmit side.
package pwm_duty_decoder_pkg;

  localparam int DUTY_W     = 4;
  localparam int CNT_W      = 8;
  localparam int NOM_PERIOD = 16;
  localparam int TIMEOUT    = 64;

  localparam logic [DUTY_W-1:0] DUTY_MAX = {DUTY_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } pwm_state_e;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Clamp a high-time count to the largest representable duty code.
  function automatic logic [DUTY_W-1:0] duty_sat(input logic [CNT_W-1:0] v);
    if (v > CNT_W'(DUTY_MAX)) begin
      return DUTY_MAX;
    end else begin
      return v[DUTY_W-1:0];
    end
  endfunction

endpackage

// File: rtl/pwm_duty_decoder_if.sv
// Result bus of the PWM duty decoder: decoded duty, measured period, the
// update strobe and the two status flags.
interface pwm_duty_decoder_if;
  import pwm_duty_decoder_pkg::*;

  logic [DUTY_W-1:0] DUTY;
  logic [CNT_W-1:0]  PERIOD;
  logic              Valid;
  logic              Period_err;
  logic              Stuck;

  modport master (
    output DUTY,
    output PERIOD,
    output Valid,
    output Period_err,
    output Stuck
  );

  modport slave (
    input DUTY,
    input PERIOD,
    input Valid,
    input Period_err,
    input Stuck
  );
endinterface

// File: rtl/pwm_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin followed by an edge
// detector. level is the synchronised value; rise/fall are single-cycle
// strobes derived from the synchronised value and its one-clock delay.
module pwm_sync_edge (
  input  logic cLK,
  input  logic Reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // Synchronise the pin and keep one extra delayed copy for edge detection
  always_ff @(posedge cLK or negedge Reset) begin
    if (!Reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= async_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign level = s2_r;
  assign rise  = s2_r & ~s3_r;
  assign fall  = ~s2_r & s3_r;

endmodule

// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder. Measures high time and period between consecutive
// synchronised rising edges, publishes a saturated duty code with a
// one-cycle Valid, and reports a stuck line after TIMEOUT idle clocks.
module pwm_duty_decoder
  import pwm_duty_decoder_pkg::*;
(
  input  logic                cLK,
  input  logic                Reset,
  input  logic                PWM_IN,
  pwm_duty_decoder_if.master  dec
);

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] IDLE_FULL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] NOM_CNT   = CNT_W'(NOM_PERIOD);

  logic level_s;
  logic rise_s;
  logic fall_s;
  logic edge_s;
  logic timeout_s;

  pwm_state_e        state_r;
  logic [CNT_W-1:0]  hi_cnt_r;
  logic [CNT_W-1:0]  per_cnt_r;
  logic [CNT_W-1:0]  idle_r;
  logic [DUTY_W-1:0] duty_r;
  logic [CNT_W-1:0]  period_r;
  logic              valid_r;
  logic              period_err_r;
  logic              stuck_r;

  pwm_sync_edge u_sync (
    .cLK      (cLK),
    .Reset    (Reset),
    .async_in (PWM_IN),
    .level    (level_s),
    .rise     (rise_s),
    .fall     (fall_s)
  );

  assign edge_s = rise_s | fall_s;

  // An edge arriving on the same clock as the timeout cancels it.
  assign timeout_s = (idle_r == IDLE_LAST) && !edge_s;

  // Idle counter: cleared by any edge, parks at TIMEOUT so a stuck line
  // produces exactly one result until the next edge.
  always_ff @(posedge cLK or negedge Reset) begin
    if (!Reset) begin
      idle_r <= '0;
    end else if (edge_s) begin
      idle_r <= '0;
    end else if (idle_r != IDLE_FULL) begin
      idle_r <= idle_r + CNT_W'(1);
    end else begin
      idle_r <= idle_r;
    end
  end

  // Measurement FSM with its counters and registered result outputs
  always_ff @(posedge cLK or negedge Reset) begin
    if (!Reset) begin
      state_r      <= WAIT_RISE;
      hi_cnt_r     <= '0;
      per_cnt_r    <= '0;
      duty_r       <= '0;
      period_r     <= '0;
      valid_r      <= 1'b0;
      period_err_r <= 1'b0;
      stuck_r      <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (timeout_s) begin
        duty_r       <= level_s ? DUTY_MAX : {DUTY_W{1'b0}};
        period_r     <= '0;
        period_err_r <= 1'b0;
        stuck_r      <= 1'b1;
        valid_r      <= 1'b1;
        state_r      <= WAIT_RISE;
      end else begin
        case (state_r)
          WAIT_RISE: begin
            // First rise only opens a frame; nothing to report yet.
            if (rise_s) begin
              hi_cnt_r  <= CNT_W'(1);
              per_cnt_r <= CNT_W'(1);
              state_r   <= HIGH;
            end
          end
          HIGH: begin
            if (fall_s) begin
              per_cnt_r <= sat_inc(per_cnt_r);
              state_r   <= LOW;
            end else begin
              hi_cnt_r  <= sat_inc(hi_cnt_r);
              per_cnt_r <= sat_inc(per_cnt_r);
            end
          end
          LOW: begin
            if (rise_s) begin
              // Closing rise: publish this frame and open the next one.
              duty_r       <= duty_sat(hi_cnt_r);
              period_r     <= per_cnt_r;
              period_err_r <= (per_cnt_r != NOM_CNT);
              stuck_r      <= 1'b0;
              valid_r      <= 1'b1;
              hi_cnt_r     <= CNT_W'(1);
              per_cnt_r    <= CNT_W'(1);
              state_r      <= HIGH;
            end else begin
              per_cnt_r <= sat_inc(per_cnt_r);
            end
          end
          default: begin
            state_r <= WAIT_RISE;
          end
        endcase
      end
    end
  end

  assign dec.DUTY       = duty_r;
  assign dec.PERIOD     = period_r;
  assign dec.Valid      = valid_r;
  assign dec.Period_err = period_err_r;
  assign dec.Stuck      = stuck_r;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder. The line is driven as runs of constant level;
// a frame-level model turns each run boundary into expected results
// (frame close on a rise, stuck-line result after a long run), and a
// monitor compares every output on every falling clock edge.
module tb_pwm_duty_decoder;

  localparam int T_OUT   = 64;
  localparam int NOM     = 16;
  localparam int D_MAX   = 15;
  localparam int C_MAX   = 255;
  localparam int LATENCY = 3;

  typedef struct {
    int         cyc;
    logic [3:0] duty;
    logic [7:0] per;
    logic       err;
    logic       stuck;
  } ev_t;

  logic cLK    = 1'b0;
  logic Reset  = 1'b0;
  logic PWM_IN = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ev_t q[$];
  ev_t ev;

  // model state
  int   last_c   = 0;
  int   t0       = 0;
  int   high_len = 0;
  logic armed    = 1'b0;
  logic to_done  = 1'b0;
  logic level    = 1'b0;
  logic cur      = 1'b0;

  // monitor expectations
  logic       e_valid = 1'b0;
  logic [3:0] e_duty  = 4'd0;
  logic [7:0] e_per   = 8'd0;
  logic       e_err   = 1'b0;
  logic       e_stuck = 1'b0;

  pwm_duty_decoder_if dif ();

  pwm_duty_decoder dut (
    .cLK    (cLK),
    .Reset  (Reset),
    .PWM_IN (PWM_IN),
    .dec    (dif)
  );

  always #5 cLK = ~cLK;

  always @(posedge cLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // A level held past T_OUT clocks since the last edge yields one stuck result.
  task automatic gap_check(input int c_next);
    ev_t e;
    if (!to_done && c_next > last_c + T_OUT) begin
      e.cyc   = last_c + T_OUT;
      e.duty  = level ? 4'd15 : 4'd0;
      e.per   = 8'd0;
      e.err   = 1'b0;
      e.stuck = 1'b1;
      q.push_back(e);
      to_done = 1'b1;
      armed   = 1'b0;
    end
  endtask

  task automatic model_edge(input int c, input logic lvl);
    ev_t e;
    int  p;
    if (lvl) begin
      if (armed) begin
        p       = imin(c - t0, C_MAX);
        e.cyc   = c;
        e.duty  = 4'(imin(high_len, D_MAX));
        e.per   = 8'(p);
        e.err   = (p != NOM);
        e.stuck = 1'b0;
        q.push_back(e);
      end
      armed = 1'b1;
      t0    = c;
    end else if (armed) begin
      high_len = imin(c - t0, C_MAX);
    end
    last_c  = c;
    to_done = 1'b0;
    level   = lvl;
  endtask

  task automatic model_release();
    last_c  = cyc;
    armed   = 1'b0;
    to_done = 1'b0;
    level   = 1'b0;
  endtask

  // Drive level lvl for n clocks, starting at a falling edge.
  task automatic run(input logic lvl, input int n);
    if (lvl !== cur) begin
      gap_check(cyc + LATENCY);
      model_edge(cyc + LATENCY, lvl);
      cur = lvl;
    end
    gap_check(cyc + n + LATENCY);
    PWM_IN = lvl;
    repeat (n) @(negedge cLK);
  endtask

  // Compare every output against the model on each falling edge
  always @(negedge cLK) begin
    if (!Reset) begin
      e_valid = 1'b0;
      e_duty  = 4'd0;
      e_per   = 8'd0;
      e_err   = 1'b0;
      e_stuck = 1'b0;
    end else begin
      e_valid = 1'b0;
      if (q.size() > 0) begin
        chk("event_not_missed", 32'(q[0].cyc >= cyc), 32'd1);
        if (q[0].cyc <= cyc) begin
          ev      = q.pop_front();
          e_valid = 1'b1;
          e_duty  = ev.duty;
          e_per   = ev.per;
          e_err   = ev.err;
          e_stuck = ev.stuck;
        end
      end
    end
    chk("valid", 32'(dif.Valid), 32'(e_valid));
    chk("duty", 32'(dif.DUTY), 32'(e_duty));
    chk("period", 32'(dif.PERIOD), 32'(e_per));
    chk("period_err", 32'(dif.Period_err), 32'(e_err));
    chk("stuck", 32'(dif.Stuck), 32'(e_stuck));
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    int l;

    // reset with the line low, then a stuck-low result at TIMEOUT
    Reset  = 1'b0;
    PWM_IN = 1'b0;
    repeat (3) @(negedge cLK);
    Reset = 1'b1;
    model_release();
    run(1'b0, 70);

    // nominal 5/11 frames: first one silent
    repeat (4) begin
      run(1'b1, 5);
      run(1'b0, 11);
    end

    // long frame saturates the duty code and flags the period
    run(1'b1, 20);
    run(1'b0, 4);

    // line stuck high, then recovery with 3/13 frames
    run(1'b1, 100);
    repeat (3) begin
      run(1'b1, 3);
      run(1'b0, 13);
    end

    // rise lands on the exact clock the idle count hits TIMEOUT
    run(1'b1, 4);
    run(1'b0, T_OUT);
    run(1'b1, 6);
    run(1'b0, 10);

    // random frames, some of nominal length
    for (int i = 0; i < 12; i++) begin
      h = $urandom_range(1, 24);
      l = $urandom_range(1, 24);
      if ((i % 3) == 0 && h < NOM) l = NOM - h;
      run(1'b1, h);
      run(1'b0, l);
    end

    // reset in the middle of a high phase clears outputs at once
    run(1'b1, 5);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_clear_duty", 32'(dif.DUTY), 32'd0);
    chk("async_clear_period", 32'(dif.PERIOD), 32'd0);
    chk("async_clear_valid", 32'(dif.Valid), 32'd0);
    chk("async_clear_err", 32'(dif.Period_err), 32'd0);
    chk("async_clear_stuck", 32'(dif.Stuck), 32'd0);
    q.delete();
    @(negedge cLK);
    PWM_IN = 1'b0;
    cur    = 1'b0;
    @(negedge cLK);
    Reset = 1'b1;
    model_release();

    // 8/8 frames after release, then a final stuck-low result
    run(1'b0, 5);
    repeat (3) begin
      run(1'b1, 8);
      run(1'b0, 8);
    end
    run(1'b1, 2);
    run(1'b0, 70);

    repeat (5) @(negedge cLK);
    chk("all_events_seen", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
